// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional FETCH_PERF_CNT_EN feature uses sat_inc for its counters.
package fetch_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned CNT_W    = 32;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, instr} buffer that parks a response while ID cannot take it.
module fetch_hold_buf
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= XLEN'(NOP);
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetch/drop/stall performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            flush_IFID,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_drop_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic            hs;
    logic            deliver;
    logic            park;
    logic            buf_clear;
    logic [XLEN-1:0] del_pc, del_instr;
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc, buf_instr;

    assign hs            = imem_req_valid && imem_req_ready;
    assign imem_req_addr = pc_q;

    fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
        .clk        (clk),
        .rstn       (rstn),
        .load       (park),
        .clear      (buf_clear),
        .load_pc    (req_pc_q),
        .load_instr (imem_rsp_data),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    // Next state, next PC and delivery/park decisions.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        deliver   = 1'b0;
        park      = 1'b0;
        buf_clear = 1'b0;
        del_pc    = req_pc_q;
        del_instr = imem_rsp_data;
        case (state_q)
            ST_REQ: begin
                if (hs) begin
                    state_d = BranchTaken ? ST_DROP : ST_WAIT;
                    pc_d    = pc_q + XLEN'(4);
                end
                if (BranchTaken) pc_d = branch_target;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                    if (BranchTaken) begin
                        pc_d = branch_target;
                    end else if (stall || flush_IFID) begin
                        // A flush only kills current IF/ID content, so the response waits a cycle.
                        park    = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        deliver = 1'b1;
                    end
                end else if (BranchTaken) begin
                    pc_d    = branch_target;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) state_d = ST_REQ;
                if (BranchTaken)    pc_d    = branch_target;
            end
            ST_HOLD: begin
                del_pc    = buf_pc;
                del_instr = buf_instr;
                if (!buf_valid) begin
                    state_d = ST_REQ;
                end else if (BranchTaken) begin
                    buf_clear = 1'b1;
                    pc_d      = branch_target;
                    state_d   = ST_REQ;
                end else if (!stall && !flush_IFID) begin
                    deliver   = 1'b1;
                    buf_clear = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_REQ;
            pc_q           <= PC_RESET;
            req_pc_q       <= '0;
            imem_req_valid <= 1'b0;
            ifid_valid     <= 1'b0;
            ifid_pc        <= '0;
            ifid_instr     <= NOP_W;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            imem_req_valid <= (state_d == ST_REQ);
            if (hs) req_pc_q <= pc_q;
            if (flush_IFID || BranchTaken) begin
                ifid_valid <= 1'b0;
                ifid_pc    <= '0;
                ifid_instr <= NOP_W;
            end else if (stall) begin
                ifid_valid <= ifid_valid;
            end else if (deliver) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= del_pc;
                ifid_instr <= del_instr;
            end else begin
                ifid_valid <= 1'b0;
                ifid_pc    <= '0;
                ifid_instr <= NOP_W;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic drop_ev;

    // Responses thrown away: killed in flight, or parked and then redirected.
    assign drop_ev = (state_q == ST_WAIT && imem_rsp_valid && BranchTaken)
                  || (state_q == ST_DROP && imem_rsp_valid)
                  || (state_q == ST_HOLD && buf_valid && BranchTaken);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (deliver && !flush_IFID && !BranchTaken && !stall)
                perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            if (drop_ev) perf_drop_cnt  <= sat_inc(perf_drop_cnt);
            if (stall)   perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`endif

endmodule
